// File: rtl/estimador_func_vadd_sat3_pkg.sv
// rtl/estimador_func_vadd_sat3_pkg.sv - shared widths, saturation constants and FSM states
package estimador_func_vadd_sat3_pkg;

   localparam int W = 32;
   localparam int N = 3;

   // Q16.16 saturation limits for the default 32-bit element
   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/estimador_func_addsat.sv
// rtl/estimador_func_addsat.sv - combinational widening adder and saturator
module estimador_func_addsat #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   sum,
   input  logic [W:0]   sum_in,
   output logic [W-1:0] result,
   output logic         sat
);

   // Stage-1 half: sign-extended W+1-bit sum never overflows
   assign sum = {a[W-1], a} + {b[W-1], b};

   // Stage-2 half: the sum is out of range exactly when its two top bits disagree
   always_comb begin
      result = sum_in[W-1:0];
      sat    = 1'b0;
      if (sum_in[W] != sum_in[W-1]) begin
         sat    = 1'b1;
         result = sum_in[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/estimador_func_vadd_sat3.sv
// rtl/estimador_func_vadd_sat3.sv - 3-element saturating vector add with ap_ctrl handshake
module estimador_func_vadd_sat3 #(
   parameter int W = 32,
   parameter int N = 3
) (
   input  logic         ap_clk,
   input  logic         ap_rst,
   input  logic         ap_start,
   output logic         ap_ready,
   output logic         ap_idle,
   output logic         ap_done,
   input  logic [W-1:0] a_0,
   input  logic [W-1:0] a_1,
   input  logic [W-1:0] a_2,
   input  logic [W-1:0] b_0,
   input  logic [W-1:0] b_1,
   input  logic [W-1:0] b_2,
   output logic [W-1:0] x_0,
   output logic [W-1:0] x_1,
   output logic [W-1:0] x_2,
   output logic         x_0_ap_vld,
   output logic         x_1_ap_vld,
   output logic         x_2_ap_vld,
   output logic         sat_flag
);

   import estimador_func_vadd_sat3_pkg::*;

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_t          state, state_next;
   logic [IW-1:0]   i;
   logic [IW-1:0]   idx_q;
   logic            pv;
   logic            sticky;
   logic [W:0]      sum_q;
   logic [W-1:0]    a_q [N];
   logic [W-1:0]    b_q [N];
   logic [W-1:0]    x_q [N];
   logic [W:0]      sum;
   logic [W-1:0]    sat_res;
   logic            sat_hit;
   logic            accept;

   assign accept = (state == S_IDLE) && ap_start;

   estimador_func_addsat #(.W(W)) u_addsat (
      .a      (a_q[i]),
      .b      (b_q[i]),
      .sum    (sum),
      .sum_in (sum_q),
      .result (sat_res),
      .sat    (sat_hit)
   );

   // State register
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state: IDLE -> RUN for N cycles -> DRAIN -> DONE -> IDLE
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (ap_start) state_next = S_RUN;
         S_RUN:   if (i == IW'(N-1)) state_next = S_DRAIN;
         S_DRAIN: state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Capture, stage-1 sum, stage-2 saturate/write and sticky saturation
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         i      <= '0;
         idx_q  <= '0;
         pv     <= 1'b0;
         sticky <= 1'b0;
         sum_q  <= '0;
         for (int k = 0; k < N; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            x_q[k] <= '0;
         end
      end else begin
         pv <= (state == S_RUN);
         if (accept) begin
            a_q[0] <= a_0;
            a_q[1] <= a_1;
            a_q[2] <= a_2;
            b_q[0] <= b_0;
            b_q[1] <= b_1;
            b_q[2] <= b_2;
            i      <= '0;
            sticky <= 1'b0;
         end
         if (state == S_RUN) begin
            sum_q <= sum;
            idx_q <= i;
            i     <= i + IW'(1);
         end
         if (pv) begin
            x_q[idx_q] <= sat_res;
            if (sat_hit) sticky <= 1'b1;
         end
      end
   end

   // Handshake outputs; ready is gated by reset since it follows ap_start directly
   always_comb begin
      ap_ready   = accept && !ap_rst;
      ap_idle    = (state == S_IDLE);
      ap_done    = (state == S_DONE);
      x_0_ap_vld = ap_done;
      x_1_ap_vld = ap_done;
      x_2_ap_vld = ap_done;
      sat_flag   = ap_done && sticky;
   end

   assign x_0 = x_q[0];
   assign x_1 = x_q[1];
   assign x_2 = x_q[2];

endmodule
